sobel_gradient: RTL and testbench

- Streaming 3x3 Sobel gradient generator.
- Consumes a raster-scan grayscale pixel stream over valid/ready and produces unsigned |Gx|, |Gy| pairs over valid/ready.
- Sits directly upstream of the magnitude stage; its output bundle (gx_o, gy_o, valid_o, ready_i) connects port-for-port to that stage's gx_i, gy_i, valid_i, ready_o.
- Only interior pixels produce output; no border padding.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/elastic.sv | 31 +++
 rtl/sobel_line_buffer.sv | 24 ++
 rtl/sobel_gradient.sv | 99 +++++++++
 tb/tb_sobel_gradient.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: Sobel kernel coefficients, 3x3 window type and gradient helpers.
package sobel_pkg;
  localparam int TAP_W = 16;
  typedef logic [TAP_W-1:0] tap_t;
  typedef tap_t win_t [3][3];
  localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  function automatic int grad_w(input int w);
    return 2 * w;
  endfunction
  // Row 0 of the window is the oldest line, column 2 the newest pixel.
  function automatic int sobel_sum(input win_t w, input logic vert);
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += (vert ? KY[r][c] : KX[r][c]) * int'(w[r][c]);
    return s;
  endfunction
endpackage

// File: rtl/elastic.sv
// elastic: single-entry valid/ready register slice, full throughput.
module elastic #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o
);
  logic valid_q, valid_d;
  logic [WIDTH_P-1:0] data_q, data_d;
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d = (ready_o && valid_i) ? data_i : data_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two previous-line stores sharing one column address.
module sobel_line_buffer #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640,
  parameter int AW_P     = $clog2(LINE_W_P)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW_P-1:0]    addr_i,
  input  logic [WIDTH_P-1:0] wdata_i,
  output logic [WIDTH_P-1:0] rd0_o,
  output logic [WIDTH_P-1:0] rd1_o
);
  logic [WIDTH_P-1:0] lb0_q [LINE_W_P];
  logic [WIDTH_P-1:0] lb1_q [LINE_W_P];
  assign rd0_o = lb0_q[addr_i];
  assign rd1_o = lb1_q[addr_i];
  // Contents are never reset so the arrays map onto RAM.
  always_ff @(posedge clk_i)
    if (we_i) begin
      lb1_q[addr_i] <= lb0_q[addr_i];
      lb0_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel |Gx|,|Gy| generator over valid/ready,
// emitting one pair per interior pixel of each raster-scan frame.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [WIDTH_P-1:0]              data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [grad_w(WIDTH_P)-1:0]      gx_o,
  output logic [grad_w(WIDTH_P)-1:0]      gy_o
);
  localparam int GW = grad_w(WIDTH_P);
  localparam int CW = $clog2(LINE_W_P);
  localparam int RW = $clog2(FRAME_H_P);
  typedef logic signed [WIDTH_P+2:0] sum_t;
  typedef logic [GW-1:0] grad_t;
  logic [WIDTH_P-1:0] win_q [3][3];
  logic [WIDTH_P-1:0] win_d [3][3];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic win_valid_q, win_valid_d;
  logic accept, el_ready, col_last, row_last;
  logic [WIDTH_P-1:0] lb0, lb1;
  logic [2*GW-1:0] el_data;
  win_t taps;
  sum_t gx_s, gy_s;
  grad_t gx_a, gy_a;
  assign ready_o = !win_valid_q || el_ready;
  assign accept = valid_i && ready_o;
  assign col_last = col_q == CW'(LINE_W_P - 1);
  assign row_last = row_q == RW'(FRAME_H_P - 1);
  sobel_line_buffer #(
    .WIDTH_P (WIDTH_P),
    .LINE_W_P(LINE_W_P),
    .AW_P    (CW)
  ) u_line_buffer (
    .clk_i  (clk_i),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(data_i),
    .rd0_o  (lb0),
    .rd1_o  (lb1)
  );
  // A held window is retired once the slice takes it, so it is never emitted twice.
  always_comb begin
    col_d = accept ? (col_last ? '0 : col_q + CW'(1)) : col_q;
    row_d = (accept && col_last) ? (row_last ? '0 : row_q + RW'(1)) : row_q;
    win_valid_d = accept ? (row_q >= RW'(2) && col_q >= CW'(2)) : (win_valid_q && !el_ready);
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = accept ? win_q[r][1] : win_q[r][0];
      win_d[r][1] = accept ? win_q[r][2] : win_q[r][1];
    end
    win_d[0][2] = accept ? lb1 : win_q[0][2];
    win_d[1][2] = accept ? lb0 : win_q[1][2];
    win_d[2][2] = accept ? data_i : win_q[2][2];
  end
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        taps[r][c] = tap_t'(win_q[r][c]);
    gx_s = sum_t'(sobel_sum(taps, 1'b0));
    gy_s = sum_t'(sobel_sum(taps, 1'b1));
    gx_a = grad_t'($unsigned(gx_s[WIDTH_P+2] ? -gx_s : gx_s));
    gy_a = grad_t'($unsigned(gy_s[WIDTH_P+2] ? -gy_s : gy_s));
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
      win_valid_q <= 1'b0;
      win_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_valid_q <= win_valid_d;
      win_q <= win_d;
    end
  elastic #(
    .WIDTH_P(2 * GW)
  ) u_out_slice (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .valid_i(win_valid_q),
    .ready_o(el_ready),
    .data_i ({gx_a, gy_a}),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (el_data)
  );
  assign {gx_o, gy_o} = el_data;
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: random and patterned 8x6 frames checked against a
// direct-convolution reference model, with backpressure and mid-frame reset.
module tb_sobel_gradient;
  localparam int W = 8;
  localparam int LW = 8;
  localparam int FH = 6;
  localparam int NOUT = (LW - 2) * (FH - 2);
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic valid_i = 1'b0;
  logic ready_i = 1'b1;
  logic [W-1:0] data_i = '0;
  logic ready_o, valid_o;
  logic [2*W-1:0] gx_o, gy_o;
  int n_chk = 0, n_err = 0, n_out = 0;
  int img [FH][LW];
  logic [31:0] exp_q [$];
  int rdy_mode = 0, burst = 0, burst_at = -1;
  bit saw_stall = 0, hold = 0;
  logic [31:0] held;

  always #5 clk_i = ~clk_i;

  sobel_gradient #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .gx_o   (gx_o),
    .gy_o   (gy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = kind == 0 ? 100 : kind == 1 ? (c >= 4 ? 255 : 0) :
                    kind == 2 ? (r >= 3 ? 255 : 0) : int'($urandom_range(0, 255));
  endtask

  task automatic model();
    int gx, gy;
    for (int r = 1; r < FH - 1; r++)
      for (int c = 1; c < LW - 1; c++) begin
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1]) - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]) - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        gx = gx < 0 ? -gx : gx;
        gy = gy < 0 ? -gy : gy;
        exp_q.push_back({16'(gx), 16'(gy)});
      end
  endtask

  task automatic send_frame(input int abort_at);
    int t;
    model();
    for (int i = 0; i < LW * FH; i++) begin
      if (i == abort_at) begin
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1 chk("pre_rst_valid", valid_o, 1);
        #1 rstn_i = 1'b0;
        #1;
        chk("rst_async_valid", valid_o, 0);
        chk("rst_async_gx", gx_o, 0);
        chk("rst_async_gy", gy_o, 0);
        exp_q.delete();
        n_out = 0;
        hold = 0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        return;
      end
      if (i == burst_at) burst = 10;
      @(negedge clk_i);
      valid_i = 1'b1;
      data_i = W'(img[i / LW][i % LW]);
      t = 0;
      while (!ready_o && t < 1000) begin
        @(negedge clk_i);
        t++;
      end
      if (t >= 1000) chk("input_timeout", t, 0);
    end
  endtask

  task automatic drain(input string tag, input int n);
    int t = 0;
    @(negedge clk_i);
    valid_i = 1'b0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    repeat (4) @(negedge clk_i);
    chk({tag, "_count"}, n_out, n);
    chk({tag, "_left"}, exp_q.size(), 0);
    n_out = 0;
  endtask

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rdy_mode == 0) ready_i = 1'b1;
    else if (burst > 0) begin
      ready_i = 1'b0;
      burst--;
    end else ready_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk_i) if (rstn_i) begin
    logic [31:0] e;
    if (hold) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_data", {gx_o, gy_o}, held);
    end
    hold = valid_o && !ready_i;
    held = {gx_o, gy_o};
    if (!ready_o) saw_stall = 1;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("extra_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("gx", gx_o, e[31:16]);
        chk("gy", gy_o, e[15:0]);
        n_out++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_gx", gx_o, 0);
    chk("rst_gy", gy_o, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    fill(0); send_frame(-1); drain("flat", NOUT);
    fill(1); send_frame(-1); drain("vert", NOUT);
    fill(2); send_frame(-1); drain("horiz", NOUT);
    fill(3); send_frame(-1); drain("rand", NOUT);
    rdy_mode = 1; burst_at = 20; saw_stall = 0;
    send_frame(-1); drain("bp", NOUT);
    chk("stall_seen", saw_stall, 1);
    rdy_mode = 0; burst_at = -1;
    fill(3); send_frame(-1);
    fill(3); send_frame(-1);
    drain("b2b", 2 * NOUT);
    fill(3); send_frame(29);
    fill(3); send_frame(-1); drain("after_rst", NOUT);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
